// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: feeds a registered bit-serial full_adder one bit per
// step, LSB first, and assembles the parallel sum.
// Each bit is held on the adder inputs for ADDER_LAT enabled clocks before
// sum/carry are sampled. The carry feeds back as the next bit's carry-in.
// Optional feature macro: SERIAL_ADD_OVF_EN adds a registered signed-overflow
// output 'ovf'.
module serial_add_sequencer #(
    parameter int WIDTH     = 8,
    parameter int ADDER_LAT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             fa_ebl,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_carry,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef SERIAL_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int CNT_W = $clog2(ADDER_LAT + 1);

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [IDX_W-1:0]   r_bit_idx;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_cout;
    logic               r_out_valid;
    logic               r_fa_ebl;
    logic               r_fa_a;
    logic               r_fa_b;
    logic               r_fa_cin;
    logic               w_accept;
    logic               w_sample;
    logic               w_last_bit;

    assign in_ready   = (r_state == IDLE);
    assign w_accept   = in_valid && in_ready;
    assign w_sample   = (r_state == DRIVE) && (r_wait_cnt == CNT_W'(ADDER_LAT));
    assign w_last_bit = (r_bit_idx == IDX_W'(WIDTH - 1));

    assign fa_ebl    = r_fa_ebl;
    assign fa_a      = r_fa_a;
    assign fa_b      = r_fa_b;
    assign fa_cin    = r_fa_cin;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign cout      = r_cout;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic.
    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_state_next = DRIVE;
            DRIVE:   if (w_sample && w_last_bit) w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Bit sequencing, adder drive and result assembly.
    // NOTE: the operand shift registers are small and reset along with
    // everything else, so no stale operand survives an aborted operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_bit_idx   <= '0;
            r_wait_cnt  <= '0;
            r_result    <= '0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
            r_fa_ebl    <= 1'b0;
            r_fa_a      <= 1'b0;
            r_fa_b      <= 1'b0;
            r_fa_cin    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a_sh     <= op_a >> 1;
                        r_b_sh     <= op_b >> 1;
                        r_fa_a     <= op_a[0];
                        r_fa_b     <= op_b[0];
                        r_fa_cin   <= cin;
                        r_bit_idx  <= '0;
                        r_wait_cnt <= '0;
                        r_fa_ebl   <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (!w_sample) begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end else begin
                        r_result[r_bit_idx] <= fa_sum;
                        if (!w_last_bit) begin
                            r_fa_a     <= r_a_sh[0];
                            r_fa_b     <= r_b_sh[0];
                            r_a_sh     <= r_a_sh >> 1;
                            r_b_sh     <= r_b_sh >> 1;
                            r_fa_cin   <= fa_carry;
                            r_bit_idx  <= r_bit_idx + 1'b1;
                            r_wait_cnt <= '0;
                        end else begin
                            r_cout      <= fa_carry;
                            r_fa_ebl    <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic r_ovf;
    assign ovf = r_ovf;

    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    r_ovf <= 1'b0;
        else if (w_sample && w_last_bit) r_ovf <= r_fa_cin ^ fa_carry;
    end
`endif

endmodule

// File: doc/serial_add_sequencer.md
Name: serial_add_sequencer

Overview:
Upstream control stage for the registered bit-serial full_adder cell. Accepts a pair of parallel WIDTH-bit operands via valid/ready and presents them to the adder one bit per step, LSB first. Holds each bit for the adder's register latency, samples sum and carry, and feeds the carry back as the next bit's carry-in. Assembles the parallel result and returns it downstream via valid/ready.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
ADDER_LAT, 3, number of enabled clocks the full_adder needs for its outputs to settle on steady inputs (>=1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  sequencer can accept operands
op_a  input  WIDTH  operand A
op_b  input  WIDTH  operand B
cin  input  1  initial carry-in
fa_ebl  output  1  enable to full_adder
fa_a  output  1  bit of A to full_adder a_in
fa_b  output  1  bit of B to full_adder b_in
fa_cin  output  1  carry to full_adder crry_in
fa_sum  input  1  full_adder sum
fa_carry  input  1  full_adder carry
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
result  output  WIDTH  A+B+cin modulo 2^WIDTH
cout  output  1  carry out of MSB

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=1; fa_ebl, fa_a, fa_b, fa_cin, out_valid, cout=0; result=0; bit_idx=0; wait_cnt=0.
- All outputs are registered except in_ready = (state==IDLE).
- FSM states: IDLE, DRIVE, DONE.
- IDLE: on in_valid&&in_ready edge, latch op_a/op_b into shift registers. Drive fa_a=op_a[0], fa_b=op_b[0], fa_cin=cin. Set bit_idx=0, wait_cnt=0, fa_ebl=1. Go to DRIVE.
- DRIVE: fa_ebl held 1; fa_a/fa_b/fa_cin held steady for the bit. wait_cnt increments each edge while < ADDER_LAT.
- Edge with wait_cnt==ADDER_LAT:
  - Capture result[bit_idx]=fa_sum; carry_q=fa_carry.
  - If bit_idx<WIDTH-1: drive next bits, fa_cin=fa_carry, bit_idx+1, wait_cnt=0.
  - Else: cout=fa_carry, fa_ebl=0, out_valid=1, go DONE.
- Per-bit cost is ADDER_LAT+1 cycles. out_valid rises exactly WIDTH*(ADDER_LAT+1) cycles after the accept edge (32 for defaults).
- DONE: result/cout/out_valid held stable while out_ready=0. On out_ready=1 edge: out_valid=0, go IDLE. No new operand is accepted on the same edge; earliest accept is the following cycle.
- in_valid while not IDLE is ignored (in_ready=0). Operand inputs need not be held after acceptance.
- fa_ebl=0 in IDLE and DONE; the adder's state is don't-care between operations, since each bit's inputs are held for ADDER_LAT enabled clocks.
- Wrap-around: sum overflow beyond WIDTH appears only on cout; result is modulo 2^WIDTH.
- Reset mid-operation: all state is cleared immediately; no out_valid for the aborted operation; in_ready=1 once rst_n deasserts.
- fa_sum/fa_carry are ignored except on sample edges.

Optional Feature:
SERIAL_ADD_OVF_EN
- Defined: adds output port ovf (1 bit, registered, reset 0). On the MSB sample edge, ovf = fa_cin ^ fa_carry (two's-complement signed overflow). Valid with out_valid and held in DONE.
- Undefined: no ovf port and no related logic.

Test Plan:
- op_a=8'h3C, op_b=8'h05, cin=0 -> result=8'h41, cout=0, out_valid exactly 32 cycles after accept; fa_ebl high for all 32 cycles.
- op_a=8'hFF, op_b=8'h01, cin=0 -> result=8'h00, cout=1 (full carry ripple through all bits).
- op_a=8'h00, op_b=8'h00, cin=1 -> result=8'h01, cout=0; op_a=8'hFF, op_b=8'hFF, cin=1 -> result=8'hFF, cout=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result/cout stable, in_ready=0, in_valid pulses ignored; release -> out_valid drops next edge, in_ready=1.
- Reset mid-op: assert rst_n=0 at cycle 12 of a DRIVE -> all outputs 0 asynchronously; after release, new op 8'h10+8'h20 -> result 8'h30.
- With SERIAL_ADD_OVF_EN: 8'h7F+8'h01 -> result 8'h80, ovf=1; 8'hFF+8'h01 -> ovf=0, cout=1.
